// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared constants, pointer type and width helper for the
//               single-clock FIFO (sync_fifo_ctrl / sync_fifo_mem).
//               Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Default geometry and thresholds used by every file in this slice
    localparam int DEFAULT_DATA_BITS           = 8;
    localparam int DEFAULT_ADDRESS_BITS        = 4;
    localparam int DEFAULT_ALMOST_FULL_THRESH  = 12;
    localparam int DEFAULT_ALMOST_EMPTY_THRESH = 4;

    // Pointer at the default depth: low bits address memory, MSB is the wrap bit
    typedef logic [DEFAULT_ADDRESS_BITS:0] ptr_t;

    // Fill level must represent 0..2**address_bits inclusive, hence one extra bit
    function automatic int fill_level_width(input int address_bits);
        return address_bits + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl_if
// Description : Handshake/data bundle between a same-clock producer/consumer
//               (master) and the FIFO (slave). Clock and reset stay outside.
//               Build option: SYNC_FIFO_FWFT_EN (affects read_data timing only).
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_ctrl_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) ();

    logic                    write_inc;
    logic [DATA_BITS-1:0]    write_data;
    logic                    read_inc;
    logic [DATA_BITS-1:0]    read_data;
    logic                    write_full;
    logic                    rempty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [ADDRESS_BITS:0]   fill_level;
    logic                    overflow;
    logic                    underflow;

    // Producer/consumer side
    modport master (
        output write_inc, write_data, read_inc,
        input  read_data, write_full, rempty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  write_inc, write_data, read_inc,
        output read_data, write_full, rempty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : 2**ADDRESS_BITS x DATA_BITS register-array storage for the
//               single-clock FIFO. Synchronous write port; read port is
//               asynchronous when SYNC_FIFO_FWFT_EN is defined, otherwise a
//               registered read that holds between read enables.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    we,
    input  wire logic [ADDRESS_BITS-1:0] waddr,
    input  wire logic [DATA_BITS-1:0]    wdata,
    input  wire logic                    re,
    input  wire logic [ADDRESS_BITS-1:0] raddr,
    output logic      [DATA_BITS-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDRESS_BITS;

    // Storage is deliberately not reset: contents survive a FIFO reset
    logic [DATA_BITS-1:0] r_mem [DEPTH];

    // Synchronous write of accepted words
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is visible combinationally; controller masks it when empty.
    // Reset and read enable have no role in this read port.
    logic w_unused;
    assign w_unused = rst ^ re;
    assign rdata    = r_mem[raddr];
`else
    logic [DATA_BITS-1:0] r_rdata;

    // Registered read: capture the head word on an accepted read, else hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO controller. Owns read/write pointers,
//               full/empty/almost flags, fill level and sticky overflow/
//               underflow flags; storage lives in sync_fifo_mem.
//               Build option: SYNC_FIFO_FWFT_EN enables first-word-fall-through
//               (read_data = head word while non-empty, 0 when empty).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_BITS           = DEFAULT_DATA_BITS,
    parameter int ADDRESS_BITS        = DEFAULT_ADDRESS_BITS,
    parameter int ALMOST_FULL_THRESH  = DEFAULT_ALMOST_FULL_THRESH,
    parameter int ALMOST_EMPTY_THRESH = DEFAULT_ALMOST_EMPTY_THRESH
) (
    input  wire logic        clk,
    input  wire logic        rst,      // synchronous, active-low
    sync_fifo_ctrl_if.slave  fifo
);

    localparam int FILL_BITS = fill_level_width(ADDRESS_BITS);

    localparam logic [FILL_BITS-1:0] c_af_thresh = FILL_BITS'(ALMOST_FULL_THRESH);
    localparam logic [FILL_BITS-1:0] c_ae_thresh = FILL_BITS'(ALMOST_EMPTY_THRESH);

    // Pointers carry one wrap bit above the memory index
    logic [ADDRESS_BITS:0]   r_wptr;
    logic [ADDRESS_BITS:0]   r_rptr;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_rempty;
    logic                    w_full;
    logic [FILL_BITS-1:0]    w_fill;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [DATA_BITS-1:0]    w_mem_rdata;

    // Flags decode from registered pointers only, so requests never reach them
    // combinationally.
    assign w_rempty = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[ADDRESS_BITS] != r_rptr[ADDRESS_BITS]) &&
                      (r_wptr[ADDRESS_BITS-1:0] == r_rptr[ADDRESS_BITS-1:0]);
    assign w_fill   = r_wptr - r_rptr;

    // Full+both: read wins, write rejected. Empty+both: write wins, read rejected.
    assign w_wr_acc = fifo.write_inc && !w_full;
    assign w_rd_acc = fifo.read_inc  && !w_rempty;

    // Pointer advance and sticky error capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (fifo.write_inc && w_full) begin
                r_overflow <= 1'b1;
            end
            if (fifo.read_inc && w_rempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_BITS    (DATA_BITS),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (r_wptr[ADDRESS_BITS-1:0]),
        .wdata (fifo.write_data),
        .re    (w_rd_acc),
        .raddr (r_rptr[ADDRESS_BITS-1:0]),
        .rdata (w_mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Stale memory must not leak out while the FIFO holds nothing
    assign fifo.read_data = w_rempty ? '0 : w_mem_rdata;
`else
    assign fifo.read_data = w_mem_rdata;
`endif

    assign fifo.rempty       = w_rempty;
    assign fifo.write_full   = w_full;
    assign fifo.fill_level   = w_fill;
    assign fifo.almost_full  = (w_fill >= c_af_thresh);
    assign fifo.almost_empty = (w_fill <= c_ae_thresh);
    assign fifo.overflow     = r_overflow;
    assign fifo.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Self-checking bench for sync_fifo_ctrl (DATA_BITS=8,
//               ADDRESS_BITS=4). Works with SYNC_FIFO_FWFT_EN defined or not.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DATA_BITS(8), .ADDRESS_BITS(4)) bus ();

    sync_fifo_ctrl #(
        .DATA_BITS           (8),
        .ADDRESS_BITS        (4),
        .ALMOST_FULL_THRESH  (12),
        .ALMOST_EMPTY_THRESH (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [7:0] m_q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;

    typedef struct {
        logic       rst_n;
        logic       wi;
        logic [7:0] wd;
        logic       ri;
        logic [4:0] fill;
        logic       empty;
        logic       full;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model and scoreboard advance alongside the DUT
    task automatic cycle(input logic rst_n, input logic wi, input logic [7:0] wd, input logic ri);
        logic       m_full, m_empty, wr_acc, rd_acc;
        logic [7:0] exp_word;
        m_full   = (m_q.size() == 16);
        m_empty  = (m_q.size() == 0);
        wr_acc   = rst_n && wi && !m_full;
        rd_acc   = rst_n && ri && !m_empty;
        exp_word = 8'h00;
        rst             = rst_n;
        bus.write_inc   = wi;
        bus.write_data  = wd;
        bus.read_inc    = ri;
        if (rd_acc) exp_word = m_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
        if (rd_acc) chk("sb_data_fwft", 32'(bus.read_data), 32'(exp_word));
`endif
        if (wr_acc) m_q.push_back(wd);
        if (rst_n && wi && m_full)  m_ovf = 1'b1;
        if (rst_n && ri && m_empty) m_unf = 1'b1;
        if (rd_acc) m_rdata = exp_word;
        if (!rst_n) begin
            m_q.delete();
            m_rdata = 8'h00;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.write_inc = 1'b0;
        bus.read_inc  = 1'b0;
        rst           = 1'b1;
`ifndef SYNC_FIFO_FWFT_EN
        if (rd_acc) chk("sb_data_reg", 32'(bus.read_data), 32'(exp_word));
        chk("rdata_hold", 32'(bus.read_data), 32'(m_rdata));
`else
        chk("rdata_fwft", 32'(bus.read_data), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
`endif
        chk("fill_level",   32'(bus.fill_level),   32'(m_q.size()));
        chk("rempty",       32'(bus.rempty),       32'(m_q.size() == 0));
        chk("write_full",   32'(bus.write_full),   32'(m_q.size() == 16));
        chk("almost_full",  32'(bus.almost_full),  32'(m_q.size() >= 12));
        chk("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= 4));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
    endtask

    initial begin
        logic seen0, seen1;
        logic [7:0] d;
        bus.write_inc  = 1'b0;
        bus.write_data = 8'h00;
        bus.read_inc   = 1'b0;

        //            rst  wi  wd     ri  fill  e  f  af ae ov un
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1, 0, 0, 1, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1, 0, 0, 1, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1, 0, 0, 1, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 0, 0, 0, 1, 0, 0};
        vecs[4] = '{1'b1, 1'b1, 8'h22, 1'b0, 5'd2, 0, 0, 0, 1, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 8'h33, 1'b1, 5'd2, 0, 0, 0, 1, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 0, 0, 0, 1, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1, 0, 0, 1, 0, 0};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1, 0, 0, 1, 0, 1};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1, 0, 0, 1, 0, 0};

        // Table: reset for 3 cycles, basic traffic, underflow, reset clears it
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].rst_n, vecs[i].wi, vecs[i].wd, vecs[i].ri);
            chk("vec_fill",  32'(bus.fill_level),   32'(vecs[i].fill));
            chk("vec_empty", 32'(bus.rempty),       32'(vecs[i].empty));
            chk("vec_full",  32'(bus.write_full),   32'(vecs[i].full));
            chk("vec_af",    32'(bus.almost_full),  32'(vecs[i].af));
            chk("vec_ae",    32'(bus.almost_empty), 32'(vecs[i].ae));
            chk("vec_ovf",   32'(bus.overflow),     32'(vecs[i].ovf));
            chk("vec_unf",   32'(bus.underflow),    32'(vecs[i].unf));
        end

        // Fill 0x00..0x0F, then overflow write
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 8'(i), 1'b0);
            chk("fill_af_edge", 32'(bus.almost_full), 32'(i + 1 >= 12));
        end
        chk("fill_full", 32'(bus.write_full), 32'h1);
        chk("fill_16",   32'(bus.fill_level), 32'd16);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 32'h1);

        // Drain in order (scoreboard), then underflow read, then rptr intact
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(bus.rempty), 32'h1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("unf_set", 32'(bus.underflow), 32'h1);
        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Wrap: 40 interleaved writes/reads with random data
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            cycle(1'b1, 1'b1, d, 1'b0);
            chk("wrap_fill_le1", 32'(bus.fill_level <= 5'd1), 32'h1);
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
            if (dut.r_wptr[4]) seen1 = 1'b1; else seen0 = 1'b1;
        end
        chk("wrap_msb_toggle", {30'd0, seen0, seen1}, 32'h3);

        // Full with both requests high: read wins
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        chk("full_both_fill", 32'(bus.fill_level), 32'd15);
        chk("full_both_ovf",  32'(bus.overflow),   32'h1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Empty with both requests high: write wins
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h99, 1'b1);
        chk("empty_both_fill", 32'(bus.fill_level), 32'd1);
        chk("empty_both_unf",  32'(bus.underflow),  32'h1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // Reset mid-stream, then 0xA5 round trip
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_fill",  32'(bus.fill_level), 32'd0);
        chk("midrst_empty", 32'(bus.rempty),     32'h1);
        cycle(1'b1, 1'b1, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("a5_fwft_visible", 32'(bus.read_data), 32'hA5);
`endif
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("a5_reg_visible", 32'(bus.read_data), 32'hA5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
